mmul_seq: RTL
=============

// Module: mmul_seq
// PURPOSE
//  Sequential shift-add mantissa multiplier for the FP datapath.
//  It is the companion of the mantissa divider: it takes two stored fractions,
//  restores the hidden 1s, forms (1.m1)*(1.m2) over WIDTH+1 cycles, then
//  normalizes and rounds the product. It returns the rounded fraction and an
//  exponent-adjust flag to the exponent unit. Handshake is start/done.
// PARAMETERS
//  WIDTH  23  stored fraction width (hidden bit excluded; 23 = single precision)
// PORTS
//  clk                 input   1      rising-edge clock
//  reset               input   1      synchronous, active-low reset
//  start               input   1      request; accepted only when ready=1
//  m1, m2              input   WIDTH  operand fractions; sampled on the accepting edge
//  ready               output  1      high in IDLE and DONE
//  done                output  1      one-cycle pulse when m3/increment_exponent are valid
//  m3                  output  WIDTH  rounded product fraction; held until next accept
//  increment_exponent  output  1      product normalized down by 1 bit (>=2.0 after rounding)
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): state=IDLE; ready=1; done=0; m3=0;
//   increment_exponent=0; internal registers cleared. Reset mid-operation
//   aborts silently: no done pulse.
//  Operands: A={1,m1}, B={1,m2} (WIDTH+1 bits each).
//   Product P is 2*WIDTH+2 bits, with 1.0 <= P < 4.0.
//  FSM:
//   IDLE : start=1 -> latch A,B; P=0; cnt=0; go to RUN.
//   RUN  : each cycle, if B[cnt]==1 add A<<cnt into P; cnt++.
//          After WIDTH+1 iterations go to ROUND.
//          Shifting the accumulator is equivalent.
//   ROUND: normalize and round; register m3 and increment_exponent; go to DONE.
//   DONE : done=1 for exactly this cycle; ready=1.
//          start=1 -> accept new operands, go to RUN.
//          Otherwise go to IDLE.
//  start while busy (RUN or ROUND) is ignored. Operands are not re-sampled.
//  Latency: start high in cycle 0 (accepted) -> done high in cycle WIDTH+3.
//   Back-to-back start in the DONE cycle gives throughput of 1 result per WIDTH+3 cycles.
//  Normalization:
//   If P[2W+1]=1: frac=P[2W:W+1], guard=P[W], sticky=|P[W-1:0], inc=1.
//   Else:         frac=P[2W-1:W], guard=P[W-1], sticky=|P[W-2:0], inc=0.
//  Rounding: round-to-nearest-even.
//   Round up iff guard & (sticky | frac[0]).
//  Round carry-out (frac all ones, rounding up):
//   - Only possible when P[2W+1]=0.
//   - Result: m3=0, increment_exponent=1.
//   - When P[2W+1]=1 carry-out is arithmetically impossible; assert it in simulation.
//  m3 and increment_exponent change only on the ROUND->DONE edge (and on reset).
//   They are stable at all other times.
//  No special-value handling (zero/inf/NaN/denormal); that is the caller's job.
// TESTING
//  W=23, m1=0, m2=0 -> done in cycle 26, m3=0, increment_exponent=0.
//  W=23, m1=m2=23'h400000 (1.5*1.5) -> m3=23'h100000, increment_exponent=1.
//  W=23, m1=m2=23'h7FFFFF -> m3=23'h7FFFFE, increment_exponent=1 (sticky only, no round-up).
//  W=4, m1=4'b0001, m2=4'b1110 (510/256) -> round carry: m3=0, increment_exponent=1.
//  W=4 ties:
//   - m1=0001, m2=1000 -> m3=4'b1010 (round to even, up).
//   - m1=0011, m2=1000 -> m3=4'b1100 (round to even, down).
//  Control:
//   - start pulsed during RUN is ignored.
//   - reset=0 in cycle 10 of an operation -> no done; outputs 0; ready=1 next cycle.
//   - start held high through DONE -> second result after another WIDTH+3 cycles.

Source files
------------

// File: rtl/mmul_seq.sv
// Sequential shift-add mantissa multiplier: (1.m1)*(1.m2), normalized and rounded to nearest-even.
// Latency WIDTH+3 cycles from accepting start to done; start is ignored while busy.
module mmul_seq #(
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] m1,
    input  logic [WIDTH-1:0] m2,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] m3,
    output logic             increment_exponent
);
    localparam int PW = 2*WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, ROUND, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH:0]    a_q, a_d;
    logic [WIDTH:0]    b_q, b_d;
    logic [PW-1:0]     p_q, p_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  m3_q, m3_d;
    logic              inc_q, inc_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    logic              hi;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [WIDTH-1:0]  frac;
    logic [WIDTH:0]    rsum;

    // Product lies in [1,4): the top bit picks which window holds the fraction.
    always_comb begin
        hi       = p_q[PW-1];
        frac     = hi ? p_q[2*WIDTH:WIDTH+1] : p_q[2*WIDTH-1:WIDTH];
        guard    = hi ? p_q[WIDTH] : p_q[WIDTH-1];
        sticky   = hi ? (|p_q[WIDTH-1:0]) : (|p_q[WIDTH-2:0]);
        round_up = guard & (sticky | frac[0]);
        rsum     = {1'b0, frac} + {{WIDTH{1'b0}}, round_up};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        m3_d    = m3_q;
        inc_d   = inc_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = {1'b1, m1};
                    b_d     = {1'b1, m2};
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (b_q[cnt_q]) p_d = p_q + (PW'(a_q) << cnt_q);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH)) state_d = ROUND;
            end
            ROUND: begin
                // A rounding carry-out means the fraction wrapped to 2.0.
                m3_d    = rsum[WIDTH-1:0];
                inc_d   = hi | rsum[WIDTH];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) || (state_d == DONE);
        done_d  = (state_q == ROUND);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            m3_q    <= '0;
            inc_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            m3_q    <= m3_d;
            inc_q   <= inc_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // With the product already >= 2.0 the shifted fraction cannot be all ones and round up.
    always_ff @(posedge clk) begin
        if (reset && state_q == ROUND) assert (!(hi && rsum[WIDTH]));
    end

    assign ready              = ready_q;
    assign done               = done_q;
    assign m3                 = m3_q;
    assign increment_exponent = inc_q;
endmodule
